// File: rtl/wb_merge_unit.sv
// Write-back merge: ch0 (in-order pipeline) plus NUM_CH-1 buffered side channels onto one regfile write port.
// Optional macro WB_LOAD_EXT_EN: extract/extend load data by funct3 and byte offset for the MEM source.
module wb_merge_unit #(
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           reg_write_wb_i,
  input  logic [4:0]                     rd_addr_wb_i,
  input  logic [1:0]                     mem_to_reg_wb_i,
  input  logic [XLEN-1:0]                ex_result_wb_i,
  input  logic [XLEN-1:0]                mem_read_data_wb_i,
  input  logic [XLEN-1:0]                pc_plus_4_wb_i,
  input  logic [2:0]                     mem_funct3_wb_i,
  input  logic [1:0]                     mem_addr_lo_wb_i,
  input  logic [NUM_CH-2:0]              ch_valid_i,
  output logic [NUM_CH-2:0]              ch_ready_o,
  input  logic [5*(NUM_CH-1)-1:0]        ch_rd_addr_i,
  input  logic [XLEN*(NUM_CH-1)-1:0]     ch_data_i,
  output logic                           reg_write_o,
  output logic [4:0]                     rd_addr_o,
  output logic [XLEN-1:0]                write_data_o,
  output logic                           wb_idle_o
);

  localparam int NSIDE = NUM_CH - 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int SW    = (NSIDE > 1) ? $clog2(NSIDE) : 1;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  logic [XLEN-1:0] mem_data_s;
  logic [XLEN-1:0] ch0_data_s;

  logic [NSIDE-1:0] empty_s;
  logic [NSIDE-1:0] full_s;
  logic [NSIDE-1:0] push_s;
  logic [NSIDE-1:0] pop_s;
  logic [4:0]       head_rd_s   [NSIDE];
  logic [XLEN-1:0]  head_data_s [NSIDE];

  logic [SW-1:0] rr_r;
  logic [SW-1:0] rr_nx_s;
  logic [SW-1:0] side_idx_s;
  logic [SW:0]   cand_s;
  logic [SW:0]   rr_inc_s;
  logic          side_found_s;
  logic          grant_side_s;

`ifdef WB_LOAD_EXT_EN
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] data,
                                                   input logic [2:0]      funct3,
                                                   input logic [1:0]      lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{lo, 3'b000} +: 8];
    h = data[{lo[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  load_extract = {{(XLEN-8){b[7]}}, b};
      3'b100:  load_extract = {{(XLEN-8){1'b0}}, b};
      3'b001:  load_extract = {{(XLEN-16){h[15]}}, h};
      3'b101:  load_extract = {{(XLEN-16){1'b0}}, h};
      default: load_extract = data;
    endcase
  endfunction

  assign mem_data_s = load_extract(mem_read_data_wb_i, mem_funct3_wb_i, mem_addr_lo_wb_i);
`else
  logic unused_s;
  assign unused_s   = ^{mem_funct3_wb_i, mem_addr_lo_wb_i};
  assign mem_data_s = mem_read_data_wb_i;
`endif

  // ch0 source select; unknown encodings fall back to the ALU result
  always_comb begin
    case (mem_to_reg_wb_i)
      WB_ALU:  ch0_data_s = ex_result_wb_i;
      WB_MEM:  ch0_data_s = mem_data_s;
      WB_PC4:  ch0_data_s = pc_plus_4_wb_i;
      default: ch0_data_s = ex_result_wb_i;
    endcase
  end

  for (genvar k = 0; k < NSIDE; k++) begin : g_fifo
    logic [4:0]      rd_mem_r   [FIFO_DEPTH];
    logic [XLEN-1:0] data_mem_r [FIFO_DEPTH];
    logic [AW:0]     wptr_r;
    logic [AW:0]     rptr_r;
    logic [AW:0]     wptr_nx_s;
    logic [AW:0]     rptr_nx_s;
    logic            full_r;

    // ready comes from the registered full flag, so a same-cycle pop never frees a slot early
    assign push_s[k]      = ch_valid_i[k] & ~full_r;
    assign wptr_nx_s      = wptr_r + {{AW{1'b0}}, push_s[k]};
    assign rptr_nx_s      = rptr_r + {{AW{1'b0}}, pop_s[k]};
    assign empty_s[k]     = (wptr_r == rptr_r);
    assign full_s[k]      = full_r;
    assign head_rd_s[k]   = rd_mem_r[rptr_r[AW-1:0]];
    assign head_data_s[k] = data_mem_r[rptr_r[AW-1:0]];

    // pointer and full-flag update
    always_ff @(posedge clk) begin
      if (rst) begin
        wptr_r <= '0;
        rptr_r <= '0;
        full_r <= 1'b0;
      end else begin
        wptr_r <= wptr_nx_s;
        rptr_r <= rptr_nx_s;
        full_r <= (wptr_nx_s[AW] != rptr_nx_s[AW]) &&
                  (wptr_nx_s[AW-1:0] == rptr_nx_s[AW-1:0]);
      end
    end

    // entry storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
      if (push_s[k]) begin
        rd_mem_r[wptr_r[AW-1:0]]   <= ch_rd_addr_i[5*k +: 5];
        data_mem_r[wptr_r[AW-1:0]] <= ch_data_i[XLEN*k +: XLEN];
      end
    end
  end

  assign ch_ready_o = ~full_s;

  // round-robin search starting at rr_r; ch0 overrides any side grant
  always_comb begin
    side_found_s = 1'b0;
    side_idx_s   = '0;
    cand_s       = '0;
    for (int i = 0; i < NSIDE; i++) begin
      cand_s = {1'b0, rr_r} + (SW+1)'(i);
      cand_s = (cand_s >= (SW+1)'(NSIDE)) ? cand_s - (SW+1)'(NSIDE) : cand_s;
      if (!side_found_s && !empty_s[cand_s[SW-1:0]]) begin
        side_found_s = 1'b1;
        side_idx_s   = cand_s[SW-1:0];
      end else begin
        side_found_s = side_found_s;
      end
    end
    grant_side_s = side_found_s & ~reg_write_wb_i;
    pop_s        = '0;
    if (grant_side_s) begin
      pop_s[side_idx_s] = 1'b1;
    end else begin
      pop_s = '0;
    end
    rr_inc_s = {1'b0, side_idx_s} + {{SW{1'b0}}, 1'b1};
    rr_nx_s  = (rr_inc_s >= (SW+1)'(NSIDE)) ? '0 : rr_inc_s[SW-1:0];
  end

  // registered write port and arbitration pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_o  <= 1'b0;
      rd_addr_o    <= 5'd0;
      write_data_o <= '0;
      rr_r         <= '0;
    end else if (reg_write_wb_i) begin
      reg_write_o  <= 1'b1;
      rd_addr_o    <= rd_addr_wb_i;
      write_data_o <= ch0_data_s;
    end else if (grant_side_s) begin
      rr_r <= rr_nx_s;
      if (head_rd_s[side_idx_s] != 5'd0) begin
        reg_write_o  <= 1'b1;
        rd_addr_o    <= head_rd_s[side_idx_s];
        write_data_o <= head_data_s[side_idx_s];
      end else begin
        reg_write_o  <= 1'b0;
      end
    end else begin
      reg_write_o <= 1'b0;
    end
  end

  assign wb_idle_o = (&empty_s) & ~reg_write_o;

endmodule

// File: tb/tb_wb_merge_unit.sv
// Directed bench for wb_merge_unit (NUM_CH=3, FIFO_DEPTH=4, XLEN=32); load-extension expectations follow WB_LOAD_EXT_EN.
module tb_wb_merge_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_wb_i;
  logic [4:0]  rd_addr_wb_i;
  logic [1:0]  mem_to_reg_wb_i;
  logic [31:0] ex_result_wb_i;
  logic [31:0] mem_read_data_wb_i;
  logic [31:0] pc_plus_4_wb_i;
  logic [2:0]  mem_funct3_wb_i;
  logic [1:0]  mem_addr_lo_wb_i;
  logic [1:0]  ch_valid_i;
  logic [1:0]  ch_ready_o;
  logic [9:0]  ch_rd_addr_i;
  logic [63:0] ch_data_i;
  logic        reg_write_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] write_data_o;
  logic        wb_idle_o;

  int n_cmp  = 0;
  int n_fail = 0;

  wb_merge_unit #(.NUM_CH(3), .FIFO_DEPTH(4), .XLEN(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .reg_write_wb_i     (reg_write_wb_i),
    .rd_addr_wb_i       (rd_addr_wb_i),
    .mem_to_reg_wb_i    (mem_to_reg_wb_i),
    .ex_result_wb_i     (ex_result_wb_i),
    .mem_read_data_wb_i (mem_read_data_wb_i),
    .pc_plus_4_wb_i     (pc_plus_4_wb_i),
    .mem_funct3_wb_i    (mem_funct3_wb_i),
    .mem_addr_lo_wb_i   (mem_addr_lo_wb_i),
    .ch_valid_i         (ch_valid_i),
    .ch_ready_o         (ch_ready_o),
    .ch_rd_addr_i       (ch_rd_addr_i),
    .ch_data_i          (ch_data_i),
    .reg_write_o        (reg_write_o),
    .rd_addr_o          (rd_addr_o),
    .write_data_o       (write_data_o),
    .wb_idle_o          (wb_idle_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ch0(input logic we, input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] ex);
    reg_write_wb_i  = we;
    rd_addr_wb_i    = rd;
    mem_to_reg_wb_i = sel;
    ex_result_wb_i  = ex;
  endtask

  initial begin
    rst = 1'b1;
    ch0(1'b0, 5'd0, 2'b00, 32'h0);
    mem_read_data_wb_i = 32'h0;
    pc_plus_4_wb_i     = 32'h0;
    mem_funct3_wb_i    = 3'b010;
    mem_addr_lo_wb_i   = 2'b00;
    ch_valid_i         = 2'b00;
    ch_rd_addr_i       = 10'd0;
    ch_data_i          = 64'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_rw",    {31'd0, reg_write_o}, 32'd0);
    chk("rst_rd",    {27'd0, rd_addr_o},   32'd0);
    chk("rst_data",  write_data_o,         32'h0);
    chk("rst_ready", {30'd0, ch_ready_o},  32'd3);
    chk("rst_idle",  {31'd0, wb_idle_o},   32'd1);

    // ch0 PC4
    ch0(1'b1, 5'd5, 2'b10, 32'h0);
    pc_plus_4_wb_i = 32'h104;
    tick();
    chk("pc4_rw",   {31'd0, reg_write_o}, 32'd1);
    chk("pc4_rd",   {27'd0, rd_addr_o},   32'd5);
    chk("pc4_data", write_data_o,         32'h104);
    ch0(1'b0, 5'd0, 2'b00, 32'h0);
    tick();
    chk("hold_rw",   {31'd0, reg_write_o}, 32'd0);
    chk("hold_rd",   {27'd0, rd_addr_o},   32'd5);
    chk("hold_data", write_data_o,         32'h104);

    // ALU and undefined select
    ch0(1'b1, 5'd7, 2'b00, 32'hDEAD_BEEF);
    tick();
    chk("alu_data", write_data_o, 32'hDEAD_BEEF);
    ch0(1'b1, 5'd8, 2'b11, 32'h1234_5678);
    tick();
    chk("undef_rd",   {27'd0, rd_addr_o}, 32'd8);
    chk("undef_data", write_data_o,       32'h1234_5678);

    // MEM: LB / LBU at offset 2
    ch0(1'b1, 5'd9, 2'b01, 32'h0);
    mem_read_data_wb_i = 32'h0080_FF00;
    mem_addr_lo_wb_i   = 2'b10;
    mem_funct3_wb_i    = 3'b000;
    tick();
`ifdef WB_LOAD_EXT_EN
    chk("lb_data", write_data_o, 32'hFFFF_FF80);
`else
    chk("lb_data", write_data_o, 32'h0080_FF00);
`endif
    mem_funct3_wb_i = 3'b100;
    tick();
`ifdef WB_LOAD_EXT_EN
    chk("lbu_data", write_data_o, 32'h0000_0080);
`else
    chk("lbu_data", write_data_o, 32'h0080_FF00);
`endif
    ch0(1'b0, 5'd0, 2'b00, 32'h0);
    tick();

    // simultaneous push on ch1/ch2, ch0 idle
    ch_valid_i   = 2'b11;
    ch_rd_addr_i = {5'd4, 5'd3};
    ch_data_i    = {32'hB, 32'hA};
    tick();
    ch_valid_i = 2'b00;
    chk("pp_rw0",   {31'd0, reg_write_o}, 32'd0);
    chk("pp_idle0", {31'd0, wb_idle_o},   32'd0);
    tick();
    chk("pp1_rw",   {31'd0, reg_write_o}, 32'd1);
    chk("pp1_rd",   {27'd0, rd_addr_o},   32'd3);
    chk("pp1_data", write_data_o,         32'hA);
    tick();
    chk("pp2_rd",   {27'd0, rd_addr_o},   32'd4);
    chk("pp2_data", write_data_o,         32'hB);
    tick();
    chk("pp_rw_end", {31'd0, reg_write_o}, 32'd0);
    chk("pp_idle",   {31'd0, wb_idle_o},   32'd1);

    // fill ch1 while ch0 writes every cycle
    for (int i = 0; i < 4; i++) begin
      ch0(1'b1, 5'd1, 2'b00, 32'h1000 + i);
      ch_valid_i   = 2'b01;
      ch_rd_addr_i = {5'd0, 5'(10 + i)};
      ch_data_i    = {32'h0, 32'h100 + i};
      tick();
      chk("fill_data",  write_data_o,        32'h1000 + i);
      chk("fill_ready", {30'd0, ch_ready_o}, (i == 3) ? 32'd2 : 32'd3);
    end
    ch0(1'b1, 5'd1, 2'b00, 32'h1004);
    ch_rd_addr_i = {5'd0, 5'd9};
    ch_data_i    = {32'h0, 32'h55};
    tick();
    chk("full_push_ready", {30'd0, ch_ready_o}, 32'd2);
    chk("full_ch0_data",   write_data_o,        32'h1004);
    ch0(1'b0, 5'd0, 2'b00, 32'h0);
    ch_valid_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_rw",   {31'd0, reg_write_o}, 32'd1);
      chk("drain_rd",   {27'd0, rd_addr_o},   32'(10 + i));
      chk("drain_data", write_data_o,         32'h100 + i);
      if (i == 0) chk("drain_ready", {30'd0, ch_ready_o}, 32'd3);
    end
    tick();
    chk("drain_end_rw", {31'd0, reg_write_o}, 32'd0);
    chk("drain_idle",   {31'd0, wb_idle_o},   32'd1);

    // rd=x0 entry is consumed without a write
    ch_valid_i   = 2'b01;
    ch_rd_addr_i = {5'd0, 5'd0};
    ch_data_i    = {32'h0, 32'h77};
    tick();
    ch_valid_i = 2'b00;
    chk("x0_idle_before", {31'd0, wb_idle_o}, 32'd0);
    tick();
    chk("x0_rw",   {31'd0, reg_write_o}, 32'd0);
    chk("x0_idle", {31'd0, wb_idle_o},   32'd1);

    // round-robin: last grant was ch1, so ch2 goes first
    ch0(1'b1, 5'd2, 2'b00, 32'h2000);
    ch_valid_i   = 2'b11;
    ch_rd_addr_i = {5'd25, 5'd24};
    ch_data_i    = {32'h251, 32'h241};
    tick();
    ch_valid_i   = 2'b01;
    ch_rd_addr_i = {5'd0, 5'd26};
    ch_data_i    = {32'h0, 32'h261};
    tick();
    chk("rr_ch0_wins", write_data_o, 32'h2000);
    ch0(1'b0, 5'd0, 2'b00, 32'h0);
    ch_valid_i = 2'b00;
    tick();
    chk("rr1_rd",   {27'd0, rd_addr_o}, 32'd25);
    chk("rr1_data", write_data_o,       32'h251);
    tick();
    chk("rr2_rd", {27'd0, rd_addr_o}, 32'd24);
    tick();
    chk("rr3_rd", {27'd0, rd_addr_o}, 32'd26);
    tick();
    chk("rr_end_rw", {31'd0, reg_write_o}, 32'd0);

    // reset with three entries buffered and a ch0 write in flight
    ch0(1'b1, 5'd2, 2'b00, 32'h2);
    ch_valid_i   = 2'b11;
    ch_rd_addr_i = {5'd21, 5'd20};
    ch_data_i    = {32'h21, 32'h20};
    tick();
    ch_valid_i   = 2'b01;
    ch_rd_addr_i = {5'd0, 5'd22};
    tick();
    chk("pre_rst_idle", {31'd0, wb_idle_o}, 32'd0);
    rst = 1'b1;
    ch0(1'b1, 5'd3, 2'b00, 32'h3333);
    ch_valid_i = 2'b11;
    tick();
    chk("mrst_rw",    {31'd0, reg_write_o}, 32'd0);
    chk("mrst_rd",    {27'd0, rd_addr_o},   32'd0);
    chk("mrst_data",  write_data_o,         32'h0);
    chk("mrst_ready", {30'd0, ch_ready_o},  32'd3);
    chk("mrst_idle",  {31'd0, wb_idle_o},   32'd1);
    rst = 1'b0;
    ch0(1'b0, 5'd0, 2'b00, 32'h0);
    ch_valid_i = 2'b00;
    tick();
    chk("post_rst_rw",   {31'd0, reg_write_o}, 32'd0);
    chk("post_rst_idle", {31'd0, wb_idle_o},   32'd1);
    tick();
    chk("post_rst_rw2", {31'd0, reg_write_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
